// File: rtl/pooling_unit.sv
// pooling_unit: streaming 1-D window pooling with a shift-register history of pooled results.
// Max pooling by default; define AVG_POOL_EN to pool by truncated average instead.
module pooling_unit #(
    parameter int DATA_W  = 8,
    parameter int WIN     = 4,
    parameter int NUM_OUT = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           En,
    input  logic [DATA_W-1:0]              convResult,
    output logic [NUM_OUT-1:0][DATA_W-1:0] pooledPixels
);
    // The oldest window slot is never a candidate, so only WIN-1 samples are stored.
    logic [WIN-2:0][DATA_W-1:0] w;
    logic [WIN-1:0][DATA_W-1:0] cand;
    logic [DATA_W-1:0]          result;

    assign cand = {w, convResult};

`ifdef AVG_POOL_EN
    localparam int SUM_W = DATA_W + $clog2(WIN);
    logic [SUM_W-1:0] sum;
    always_comb begin
        sum = '0;
        for (int i = 0; i < WIN; i++) sum = sum + SUM_W'(cand[i]);
    end
    assign result = DATA_W'(sum >> $clog2(WIN));
`else
    always_comb begin
        result = cand[0];
        for (int i = 1; i < WIN; i++) result = cand[i] > result ? cand[i] : result;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w            <= '0;
            pooledPixels <= '0;
        end else begin
            w <= cand[WIN-2:0];
            if (En) pooledPixels <= {pooledPixels[NUM_OUT-2:0], result};
        end
    end
endmodule

// File: tb/tb_pooling_unit.sv
// tb_pooling_unit: directed and random checks of pooling_unit against a queue-based window model.
module tb_pooling_unit;
    logic            clk = 0;
    logic            rst_n;
    logic            En;
    logic [7:0]      convResult;
    logic [3:0][7:0] pooledPixels;
    logic [3:0][7:0] expHist;
    logic [7:0]      recent[$];
    int              vectors = 0;
    int              miscompares = 0;

    pooling_unit dut (
        .clk(clk), .rst_n(rst_n), .En(En),
        .convResult(convResult), .pooledPixels(pooledPixels)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] poolOf(input logic [7:0] s0, s1, s2, s3);
`ifdef AVG_POOL_EN
        int total = int'(s0) + int'(s1) + int'(s2) + int'(s3);
        return 8'(total / 4);
`else
        int best = 0;
        foreach (recent[i]) best = (i < 4 && int'(recent[i]) > best) ? int'(recent[i]) : best;
        return 8'(best);
`endif
    endfunction

    task automatic modelReset();
        recent  = '{8'h00, 8'h00, 8'h00};
        expHist = '0;
    endtask

    task automatic check(input string tag);
        vectors++;
        assert (pooledPixels === expHist) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, pooledPixels, expHist);
        end
    endtask

    task automatic checkConst(input string tag, input logic [3:0][7:0] want);
        vectors++;
        assert (pooledPixels === want) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, pooledPixels, want);
        end
    endtask

    task automatic step(input logic [7:0] d, input logic e, input string tag);
        convResult = d;
        En = e;
        @(posedge clk);
        recent.push_front(d);
        if (e) expHist = {expHist[2:0], poolOf(recent[0], recent[1], recent[2], recent[3])};
        while (recent.size() > 3) void'(recent.pop_back());
        #1 check(tag);
    endtask

    initial begin
        rst_n = 0;
        En = 0;
        convResult = 0;
        modelReset();
        #8 checkConst("reset", '0);
        #4 rst_n = 1;

        step(8'h31, 0, "basic0");
        step(8'h32, 0, "basic1");
        step(8'h38, 0, "basic2");
        step(8'h07, 1, "basic3");
`ifdef AVG_POOL_EN
        checkConst("basicConst", {8'h00, 8'h00, 8'h00, 8'h28});
`else
        checkConst("basicConst", {8'h00, 8'h00, 8'h00, 8'h38});
`endif

        step(8'h01, 0, "second0");
        step(8'h00, 0, "second1");
        step(8'h33, 0, "second2");
        step(8'hFC, 1, "second3");
`ifdef AVG_POOL_EN
        checkConst("secondConst", {8'h00, 8'h00, 8'h28, 8'h4C});
`else
        checkConst("secondConst", {8'h00, 8'h00, 8'h38, 8'hFC});
`endif

        for (int i = 0; i < 10; i++) step(8'($urandom), 0, "hold");
`ifdef AVG_POOL_EN
        checkConst("holdConst", {8'h00, 8'h00, 8'h28, 8'h4C});
`else
        checkConst("holdConst", {8'h00, 8'h00, 8'h38, 8'hFC});
`endif

        for (int k = 1; k <= 5; k++) begin
            int pos = $urandom_range(0, 3);
            for (int j = 0; j < 4; j++)
                step(j == pos ? 8'(16 * k) : 8'($urandom_range(0, 16 * k - 1)), j == 3, "overflow");
        end
`ifndef AVG_POOL_EN
        checkConst("overflowConst", {8'h20, 8'h30, 8'h40, 8'h50});
`endif

        // Mid-cycle reset must clear the nonzero history without waiting for an edge.
        rst_n = 0;
        #1 modelReset();
        checkConst("asyncReset", '0);
        @(negedge clk) rst_n = 1;
        step(8'h05, 1, "earlyEn");
`ifndef AVG_POOL_EN
        checkConst("earlyConst", {8'h00, 8'h00, 8'h00, 8'h05});
`endif

        step(8'h44, 1, "consec0");
        step(8'h12, 1, "consec1");

        step(8'h7F, 0, "unsigned0");
        step(8'hFF, 0, "unsigned1");
        step(8'h00, 0, "unsigned2");
        step(8'h10, 1, "unsigned3");
`ifndef AVG_POOL_EN
        vectors++;
        assert (pooledPixels[0] === 8'hFF) else begin
            miscompares++;
            $error("FAIL unsignedConst: observed %h expected ff", pooledPixels[0]);
        end
`endif

        for (int i = 0; i < 200; i++) step(8'($urandom), $urandom_range(0, 2) == 0, "random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
